// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment scan driver:
// the hex-to-segment table (active-low, g..a), blank patterns and the digit-index type.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] DIG_OFF = 4'hF;

    typedef logic [1:0] dig_idx_t;

    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low digit enable: only the selected digit's bit is 0.
    function automatic logic [3:0] one_cold(input dig_idx_t idx);
        logic [3:0] r;
        r = DIG_OFF;
        r[idx] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low g..a segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex display driver with frame-boundary double buffering.
// Optional build macro SEG7_LZ_BLANK_EN blanks leading zero digits of the displayed value.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iDATA,
    input  logic        iVALID,
    output logic [6:0]  oSEG,
    output logic [3:0]  oDIG,
    output logic        oFRAME
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q;
    dig_idx_t      idx_q;
    logic [15:0]   shadow_q;
    logic [15:0]   active_q;
    logic          pending_q;
    logic [6:0]    seg_q;
    logic [3:0]    dig_q;
    logic          frame_q;

    logic          tick;
    logic          wrap;
    logic          blank;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;
    logic [6:0]    seg_d;
    logic [3:0]    dig_d;

    assign tick = (cnt_q == CW'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == 2'd3);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (cnt_q < CW'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        nibble = active_q[3:0];
        case (idx_q)
            2'd0: nibble = active_q[3:0];
            2'd1: nibble = active_q[7:4];
            2'd2: nibble = active_q[11:8];
            2'd3: nibble = active_q[15:12];
            default: nibble = active_q[3:0];
        endcase
    end

    seg7_hex_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (hex_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
    logic [3:0] lz_blank;
    assign lz_blank = {(active_q[15:12] == 4'd0),
                       (active_q[15:8]  == 8'd0),
                       (active_q[15:4]  == 12'd0),
                       1'b0};
    assign seg_d = lz_blank[idx_q] ? SEG_OFF : hex_seg;
`else
    assign seg_d = hex_seg;
`endif

    assign dig_d = blank ? DIG_OFF : one_cold(idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
            if (iVALID) begin
                shadow_q <= iDATA;
            end
            // Commit uses the pre-edge shadow; a same-cycle write stays pending for the next wrap.
            if (wrap && pending_q) begin
                active_q <= shadow_q;
            end
            if (iVALID) begin
                pending_q <= 1'b1;
            end else if (wrap) begin
                pending_q <= 1'b0;
            end
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= wrap;
        end
    end

    assign oSEG   = seg_q;
    assign oDIG   = dig_q;
    assign oFRAME = frame_q;

endmodule
